// File: rtl/multistart_pkg.sv
// Shared types and Q24.8 helpers for the multistart sequencer.
package multistart_pkg;

  localparam int          Q_FRAC_BITS = 8;
  localparam logic [31:0] Q_MAX       = 32'h7FFF_FFFF;
  localparam logic [31:0] Q_MIN       = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LAUNCH,
    ST_WAIT_DONE,
    ST_RELEASE,
    ST_FINISH
  } state_e;

  // Signed 32-bit add that clamps instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {a[31], a} + {b[31], b};
    if (sum[32] != sum[31]) return sum[32] ? Q_MIN : Q_MAX;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/multistart_sequencer_if.sv
// Sweep request/result port plus minimizer handshake port of the multistart sequencer.
interface multistart_sequencer_if;
  logic        sweep_start;
  logic        sweep_busy;
  logic        sweep_done;
  logic        sweep_error;
  logic        run_start_op;
  logic [31:0] run_x_in;
  logic        run_done_op;
  logic [31:0] run_x_at_min;
  logic [31:0] run_y_min;
  logic [31:0] best_x;
  logic [31:0] best_y;
  logic [7:0]  best_idx;

  modport slave (
    input  sweep_start, run_done_op, run_x_at_min, run_y_min,
    output sweep_busy, sweep_done, sweep_error, run_start_op, run_x_in,
           best_x, best_y, best_idx
  );

  modport master (
    output sweep_start, run_done_op, run_x_at_min, run_y_min,
    input  sweep_busy, sweep_done, sweep_error, run_start_op, run_x_in,
           best_x, best_y, best_idx
  );
endinterface

// File: rtl/multistart_sequencer_best_tracker.sv
// Keeps the best (smallest signed y) run of a sweep; ties keep the earlier run.
module best_tracker (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        capture_i,
  input  logic [7:0]  idx_i,
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  output logic [31:0] best_x_o,
  output logic [31:0] best_y_o,
  output logic [7:0]  best_idx_o
);

  logic        have_best_q;
  logic [31:0] best_x_q;
  logic [31:0] best_y_q;
  logic [7:0]  best_idx_q;
  logic        take;

  assign take = capture_i && (!have_best_q || ($signed(y_i) < $signed(best_y_q)));

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      have_best_q <= 1'b0;
      best_x_q    <= '0;
      best_y_q    <= '0;
      best_idx_q  <= '0;
    end else begin
      if (take) begin
        best_x_q   <= x_i;
        best_y_q   <= y_i;
        best_idx_q <= idx_i;
      end
      // best_* survive a clear so results stay visible between sweeps.
      if (clear_i)   have_best_q <= 1'b0;
      else if (take) have_best_q <= 1'b1;
    end
  end

  assign best_x_o   = best_x_q;
  assign best_y_o   = best_y_q;
  assign best_idx_o = best_idx_q;

endmodule

// File: rtl/multistart_sequencer.sv
// Sweeps NUM_STARTS start points through the minimizer and keeps the global best.
// Optional watchdog in WAIT_DONE enabled by defining MULTISTART_TIMEOUT_EN.
module multistart_sequencer
  import multistart_pkg::*;
#(
  parameter int unsigned NUM_STARTS     = 8,
  parameter logic [31:0] X_START        = 32'hFFFF_F000,
  parameter logic [31:0] X_STEP         = 32'h0000_0400,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic                   clk,
  input logic                   rst,
  multistart_sequencer_if.slave bus
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_STARTS - 1);

  state_e      state_q;
  logic [31:0] x_cur_q;
  logic [7:0]  idx_q;
  logic        clear_best;
  logic        capture_best;

`ifdef MULTISTART_TIMEOUT_EN
  logic        sweep_error_q;
  logic [31:0] tmo_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_cur_q <= '0;
      idx_q   <= '0;
`ifdef MULTISTART_TIMEOUT_EN
      sweep_error_q <= 1'b0;
      tmo_cnt_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.sweep_start) begin
`ifdef MULTISTART_TIMEOUT_EN
            sweep_error_q <= 1'b0;
`endif
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          x_cur_q <= X_START;
          idx_q   <= '0;
          state_q <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
`ifdef MULTISTART_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (bus.run_done_op) begin
            state_q <= ST_RELEASE;
          end
`ifdef MULTISTART_TIMEOUT_EN
          else if (tmo_cnt_q == TIMEOUT_CYCLES - 1) begin
            sweep_error_q <= 1'b1;
            state_q       <= ST_FINISH;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1;
          end
`endif
        end
        ST_RELEASE: begin
          // The minimizer must be back in idle before the next start level.
          if (!bus.run_done_op) begin
            if (idx_q == LAST_IDX) begin
              state_q <= ST_FINISH;
            end else begin
              idx_q   <= idx_q + 8'd1;
              x_cur_q <= sat_add32(x_cur_q, X_STEP);
              state_q <= ST_LAUNCH;
            end
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign clear_best   = (state_q == ST_LOAD);
  assign capture_best = (state_q == ST_WAIT_DONE) && bus.run_done_op;

  best_tracker u_best (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear_best),
    .capture_i  (capture_best),
    .idx_i      (idx_q),
    .x_i        (bus.run_x_at_min),
    .y_i        (bus.run_y_min),
    .best_x_o   (bus.best_x),
    .best_y_o   (bus.best_y),
    .best_idx_o (bus.best_idx)
  );

  assign bus.run_start_op = (state_q == ST_LAUNCH) || (state_q == ST_WAIT_DONE);
  assign bus.run_x_in     = x_cur_q;
  assign bus.sweep_busy   = state_q inside {ST_LOAD, ST_LAUNCH, ST_WAIT_DONE, ST_RELEASE};
  assign bus.sweep_done   = (state_q == ST_FINISH);

`ifdef MULTISTART_TIMEOUT_EN
  assign bus.sweep_error = sweep_error_q;
`else
  assign bus.sweep_error = 1'b0;
`endif

endmodule
